// File: rtl/counter_uni_n.sv
// Parametrised up/down counter with programmable modulus (MAXV+1) and step,
// wrap or stop range behaviour, sticky stop-mode overflow and terminal count.
module counter_uni_n #(
    parameter int WIDTH = 8,
    parameter int MAXV  = 2**WIDTH - 1,
    parameter int STEPW = WIDTH
) (
    input  logic             clk,
    input  logic             _reset,
    input  logic             en,
    input  logic             _set,
    input  logic             _load,
    input  logic [WIDTH-1:0] preld_val,
    input  logic             _updown,
    input  logic             _wrapstop,
    input  logic [STEPW-1:0] step,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] dcout,
    output logic             overflow,
    output logic             tc
);

    localparam int IW = ((WIDTH > STEPW) ? WIDTH : STEPW) + 1;
    localparam logic [IW-1:0]    MOD_X  = IW'(MAXV + 1);
    localparam logic [IW-1:0]    MAXV_X = IW'(MAXV);
    localparam logic [WIDTH-1:0] MAXV_C = WIDTH'(MAXV);

    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] STOP = 1'b1;

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [0:0]       state_q, state_d;

    logic [IW-1:0] cnt_x, step_m, sum_x, pre_x;

    assign cnt_x  = IW'(cnt_q);
    assign pre_x  = IW'(preld_val);
    assign step_m = IW'(step) % MOD_X;
    assign sum_x  = cnt_x + step_m;

    always_comb begin
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        state_d = state_q;
        if (_set) begin
            cnt_d   = MAXV_C;
            ovf_d   = 1'b0;
            state_d = RUN;
        end else if (_load) begin
            cnt_d   = (pre_x > MAXV_X) ? MAXV_C : preld_val;
            ovf_d   = 1'b0;
            state_d = RUN;
        end else if (ovf_clr) begin
            ovf_d   = 1'b0;
            state_d = RUN;
        end else if (state_q == RUN && en) begin
            ovf_d = 1'b0;
            if (_updown) begin
                if (sum_x <= MAXV_X) begin
                    cnt_d = WIDTH'(sum_x);
                end else if (_wrapstop) begin
                    cnt_d = WIDTH'(sum_x - MOD_X);
                    ovf_d = 1'b1;
                end else begin
                    cnt_d   = MAXV_C;
                    ovf_d   = 1'b1;
                    state_d = STOP;
                end
            end else begin
                if (step_m <= cnt_x) begin
                    cnt_d = WIDTH'(cnt_x - step_m);
                end else if (_wrapstop) begin
                    cnt_d = WIDTH'(cnt_x + MOD_X - step_m);
                    ovf_d = 1'b1;
                end else begin
                    cnt_d   = '0;
                    ovf_d   = 1'b1;
                    state_d = STOP;
                end
            end
        end else if (state_q == RUN && _wrapstop) begin
            // STOP keeps its sticky flag even if _wrapstop changes meanwhile
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!_reset) begin
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            state_q <= RUN;
        end else begin
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            state_q <= state_d;
        end
    end

    assign dcout    = cnt_q;
    assign overflow = ovf_q;
    assign tc       = _updown ? (cnt_q == MAXV_C) : (cnt_q == '0);

endmodule

// File: tb/tb_counter_uni_n.sv
// Directed vector bench for counter_uni_n: an 8-bit full-range instance and a
// 4-bit mod-10 instance, driven from tables plus a few hand sequences.
module tb_counter_uni_n;

    typedef struct {
        bit       rst_n, set, load, en, ud, ws, clr;
        bit [7:0] pre, stp;
        bit [7:0] e_cnt;
        bit       e_ovf, e_tc;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n, set, load, en, ud, ws, clr;
    logic [7:0] pre8, stp8;
    logic [7:0] a_cnt;
    logic       a_ovf, a_tc;
    logic [3:0] b_cnt;
    logic       b_ovf, b_tc;

    int n_tests = 0;
    int n_fail  = 0;

    vec_t tab_a[$];
    vec_t tab_b[$];

    always #5 clk = ~clk;

    counter_uni_n #(.WIDTH(8), .MAXV(255), .STEPW(8)) dut_a (
        .clk(clk), ._reset(rst_n), .en(en), ._set(set), ._load(load),
        .preld_val(pre8), ._updown(ud), ._wrapstop(ws), .step(stp8),
        .ovf_clr(clr), .dcout(a_cnt), .overflow(a_ovf), .tc(a_tc)
    );

    counter_uni_n #(.WIDTH(4), .MAXV(9), .STEPW(4)) dut_b (
        .clk(clk), ._reset(rst_n), .en(en), ._set(set), ._load(load),
        .preld_val(pre8[3:0]), ._updown(ud), ._wrapstop(ws), .step(stp8[3:0]),
        .ovf_clr(clr), .dcout(b_cnt), .overflow(b_ovf), .tc(b_tc)
    );

    function automatic vec_t mk(bit r, bit s, bit l, bit e, bit u, bit w, bit c,
                                int p, int st, int ec, bit eo, bit et);
        vec_t v;
        v.rst_n = r; v.set = s; v.load = l; v.en = e; v.ud = u; v.ws = w; v.clr = c;
        v.pre = 8'(p); v.stp = 8'(st); v.e_cnt = 8'(ec); v.e_ovf = eo; v.e_tc = et;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0d, want %0d", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        @(negedge clk);
        rst_n = v.rst_n; set = v.set; load = v.load; en = v.en;
        ud = v.ud; ws = v.ws; clr = v.clr; pre8 = v.pre; stp8 = v.stp;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_step(input bit e);
        @(negedge clk);
        rst_n = 1'b1; set = 1'b0; load = 1'b0; clr = 1'b0; en = e;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; set = 1'b0; load = 1'b0; en = 1'b0;
        ud = 1'b0; ws = 1'b1; clr = 1'b0; pre8 = '0; stp8 = '0;

        //             rst set ld en ud ws clr pre   stp  cnt  ovf tc
        tab_a.push_back(mk(0, 0, 0, 0, 0, 1, 0,   0,   0,   0, 0, 1));
        // up wrap step 1 from 254
        tab_a.push_back(mk(1, 0, 1, 0, 1, 1, 0, 254,   1, 254, 0, 0));
        tab_a.push_back(mk(1, 0, 0, 1, 1, 1, 0,   0,   1, 255, 0, 1));
        tab_a.push_back(mk(1, 0, 0, 1, 1, 1, 0,   0,   1,   0, 1, 0));
        tab_a.push_back(mk(1, 0, 0, 1, 1, 1, 0,   0,   1,   1, 0, 0));
        // down stop step 5 from 7, sticky overflow, ovf_clr
        tab_a.push_back(mk(1, 0, 1, 0, 0, 0, 0,   7,   5,   7, 0, 0));
        tab_a.push_back(mk(1, 0, 0, 1, 0, 0, 0,   0,   5,   2, 0, 0));
        tab_a.push_back(mk(1, 0, 0, 1, 0, 0, 0,   0,   5,   0, 1, 1));
        tab_a.push_back(mk(1, 0, 0, 1, 0, 0, 0,   0,   5,   0, 1, 1));
        tab_a.push_back(mk(1, 0, 0, 1, 0, 0, 0,   0,   5,   0, 1, 1));
        tab_a.push_back(mk(1, 0, 0, 1, 0, 0, 0,   0,   5,   0, 1, 1));
        tab_a.push_back(mk(1, 0, 0, 0, 0, 0, 1,   0,   5,   0, 0, 1));
        tab_a.push_back(mk(1, 0, 0, 1, 0, 0, 0,   0,   5,   0, 1, 1));
        tab_a.push_back(mk(1, 0, 0, 1, 0, 0, 1,   0,   5,   0, 0, 1));
        tab_a.push_back(mk(1, 0, 0, 1, 0, 0, 0,   0,   5,   0, 1, 1));
        // priority
        tab_a.push_back(mk(0, 1, 1, 1, 0, 0, 0,  16,   5,   0, 0, 1));
        tab_a.push_back(mk(1, 1, 1, 0, 0, 0, 0,  16,   5, 255, 0, 0));
        tab_a.push_back(mk(1, 0, 1, 1, 0, 0, 0,  16,   5,  16, 0, 0));
        // reset in STOP, then resume
        tab_a.push_back(mk(1, 0, 1, 0, 1, 0, 0, 200, 100, 200, 0, 0));
        tab_a.push_back(mk(1, 0, 0, 1, 1, 0, 0,   0, 100, 255, 1, 1));
        tab_a.push_back(mk(1, 0, 0, 1, 1, 0, 0,   0, 100, 255, 1, 1));
        tab_a.push_back(mk(0, 0, 0, 1, 1, 0, 0,   0, 100,   0, 0, 0));
        tab_a.push_back(mk(1, 0, 0, 1, 1, 0, 0,   0, 100, 100, 0, 0));
        // down wrap, then back-to-back up wraps
        tab_a.push_back(mk(1, 0, 1, 0, 0, 1, 0,   1,   3,   1, 0, 0));
        tab_a.push_back(mk(1, 0, 0, 1, 0, 1, 0,   0,   3, 254, 1, 0));
        tab_a.push_back(mk(1, 0, 0, 1, 0, 1, 0,   0,   3, 251, 0, 0));
        tab_a.push_back(mk(1, 0, 0, 1, 1, 1, 0,   0, 200, 195, 1, 0));
        tab_a.push_back(mk(1, 0, 0, 1, 1, 1, 0,   0, 200, 139, 1, 0));
        tab_a.push_back(mk(1, 0, 0, 0, 1, 1, 0,   0, 200, 139, 0, 0));

        // mod-10, 4-bit instance
        tab_b.push_back(mk(0, 0, 0, 0, 1, 1, 0,   0,   3,   0, 0, 0));
        tab_b.push_back(mk(1, 0, 0, 1, 1, 1, 0,   0,   3,   3, 0, 0));
        tab_b.push_back(mk(1, 0, 0, 1, 1, 1, 0,   0,   3,   6, 0, 0));
        tab_b.push_back(mk(1, 0, 0, 1, 1, 1, 0,   0,   3,   9, 0, 1));
        tab_b.push_back(mk(1, 0, 0, 1, 1, 1, 0,   0,   3,   2, 1, 0));
        tab_b.push_back(mk(1, 0, 0, 1, 1, 1, 0,   0,   3,   5, 0, 0));
        // saturating load, zero step
        tab_b.push_back(mk(1, 0, 1, 0, 1, 1, 0,  14,   0,   9, 0, 1));
        tab_b.push_back(mk(1, 0, 0, 1, 1, 1, 0,   0,   0,   9, 0, 1));
        // step 13 behaves as 3
        tab_b.push_back(mk(1, 0, 1, 0, 1, 1, 0,   0,  13,   0, 0, 0));
        tab_b.push_back(mk(1, 0, 0, 1, 1, 1, 0,   0,  13,   3, 0, 0));
        // down wrap modulo 10
        tab_b.push_back(mk(1, 0, 0, 1, 0, 1, 0,   0,   5,   8, 1, 0));
        // set, then down stop
        tab_b.push_back(mk(1, 1, 0, 0, 0, 0, 0,   0,   4,   9, 0, 0));
        tab_b.push_back(mk(1, 0, 0, 1, 0, 0, 0,   0,   4,   5, 0, 0));
        tab_b.push_back(mk(1, 0, 0, 1, 0, 0, 0,   0,   4,   1, 0, 0));
        tab_b.push_back(mk(1, 0, 0, 1, 0, 0, 0,   0,   4,   0, 1, 1));
        tab_b.push_back(mk(1, 0, 0, 1, 0, 0, 0,   0,   4,   0, 1, 1));

        foreach (tab_a[i]) begin
            drive(tab_a[i]);
            chk("a_cnt", i, int'(a_cnt), int'(tab_a[i].e_cnt));
            chk("a_ovf", i, int'(a_ovf), int'(tab_a[i].e_ovf));
            chk("a_tc",  i, int'(a_tc),  int'(tab_a[i].e_tc));
        end

        foreach (tab_b[i]) begin
            drive(tab_b[i]);
            chk("b_cnt", i, int'(b_cnt), int'(tab_b[i].e_cnt));
            chk("b_ovf", i, int'(b_ovf), int'(tab_b[i].e_ovf));
            chk("b_tc",  i, int'(b_tc),  int'(tab_b[i].e_tc));
        end

        // STOP ignores a change to wrap mode until it is exited
        drive(mk(1, 0, 1, 0, 1, 0, 0, 250, 10, 250, 0, 0));
        idle_step(1'b1);
        chk("seq_stop_cnt", 0, int'(a_cnt), 255);
        chk("seq_stop_ovf", 0, int'(a_ovf), 1);
        @(negedge clk);
        ws = 1'b1;
        for (int unsigned k = 0; k < 2; k++) begin
            idle_step(1'b1);
            chk("seq_ws_cnt", int'(k), int'(a_cnt), 255);
            chk("seq_ws_ovf", int'(k), int'(a_ovf), 1);
        end
        // tc follows _updown without a clock edge
        @(negedge clk);
        ud = 1'b0;
        #1;
        chk("seq_tc_dn", 0, int'(a_tc), 0);
        ud = 1'b1;
        #1;
        chk("seq_tc_up", 0, int'(a_tc), 1);
        // clear leaves STOP; wrap mode now applies
        @(negedge clk);
        clr = 1'b1; en = 1'b0;
        @(posedge clk);
        #1;
        chk("seq_clr_ovf", 0, int'(a_ovf), 0);
        idle_step(1'b1);
        chk("seq_wrap_cnt", 0, int'(a_cnt), 9);
        chk("seq_wrap_ovf", 0, int'(a_ovf), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
